// File: rtl/set_associative_cache_unit_plru.sv
// set_associative_cache_unit_plru: 2**SET_ASSOCIATIVITY-way tag/state/data array with tree PLRU,
// registered 1-cycle CPU lookup/write/install and a concurrent snoop probe/invalidate port.
module set_associative_cache_unit_plru #(
    parameter int TAG_WIDTH         = 6,
    parameter int INDEX_WIDTH       = 6,
    parameter int OFFSET_WIDTH      = 4,
    parameter int SET_ASSOCIATIVITY = 2,
    parameter int DATA_WIDTH        = 16,
    parameter int STATE_WIDTH       = 2,
    parameter int INVALID_STATE     = 0,
    localparam int AW = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH,
    localparam int WW = SET_ASSOCIATIVITY > 0 ? SET_ASSOCIATIVITY : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [AW-1:0]          cpu_address_i,
    input  logic                   cpu_access_enable_i,
    input  logic                   cpu_write_enable_i,
    input  logic                   cpu_install_enable_i,
    input  logic [DATA_WIDTH-1:0]  cpu_data_i,
    input  logic [STATE_WIDTH-1:0] cpu_state_i,
    input  logic                   cpu_state_write_enable_i,
    output logic                   cpu_valid_o,
    output logic                   cpu_hit_o,
    output logic                   cpu_conflict_o,
    output logic [WW-1:0]          cpu_way_o,
    output logic [DATA_WIDTH-1:0]  cpu_data_o,
    output logic [STATE_WIDTH-1:0] cpu_state_o,
    output logic [TAG_WIDTH-1:0]   cpu_victim_tag_o,
    input  logic [AW-1:0]          snoop_address_i,
    input  logic                   snoop_enable_i,
    input  logic                   snoop_invalidate_enable_i,
    output logic                   snoop_valid_o,
    output logic                   snoop_hit_o,
    output logic [STATE_WIDTH-1:0] snoop_state_o
);
    localparam int WAYS  = 1 << SET_ASSOCIATIVITY;
    localparam int SETS  = 1 << INDEX_WIDTH;
    localparam int WORDS = 1 << OFFSET_WIDTH;
    localparam logic [STATE_WIDTH-1:0] INV = STATE_WIDTH'(INVALID_STATE);

    logic [TAG_WIDTH-1:0]   tag_q   [SETS][WAYS];
    logic [STATE_WIDTH-1:0] state_q [SETS][WAYS];
    logic [DATA_WIDTH-1:0]  data_q  [SETS][WAYS][WORDS];
    // Heap-ordered tree: node n lives at bit n (1..WAYS-1); a bit of 1 sends the victim to the upper half.
    logic [WAYS-1:0]        plru_q  [SETS];

    logic [TAG_WIDTH-1:0]    c_tag, s_tag;
    logic [INDEX_WIDTH-1:0]  c_set, s_set;
    logic [OFFSET_WIDTH-1:0] c_off;
    logic                    unused_snoop_offset;

    assign c_tag = cpu_address_i[AW-1 -: TAG_WIDTH];
    assign c_set = cpu_address_i[OFFSET_WIDTH +: INDEX_WIDTH];
    assign c_off = cpu_address_i[OFFSET_WIDTH-1:0];
    assign s_tag = snoop_address_i[AW-1 -: TAG_WIDTH];
    assign s_set = snoop_address_i[OFFSET_WIDTH +: INDEX_WIDTH];
    assign unused_snoop_offset = ^snoop_address_i[OFFSET_WIDTH-1:0];

    logic                   c_hit, s_hit, inv_found;
    logic [WW-1:0]          c_hway, s_hway, inv_way, plru_way, victim, sel_way, wbit;
    logic [WAYS-1:0]        pbits, plru_new;
    int                     vnode, unode;
    logic                   s_inv, conflict, go, do_inst, do_write, do_state, do_plru;
    logic [STATE_WIDTH-1:0] ev_state;

    always_comb begin
        c_hit     = 1'b0;
        c_hway    = '0;
        s_hit     = 1'b0;
        s_hway    = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (state_q[c_set][w] != INV && tag_q[c_set][w] == c_tag) begin
                c_hit  = 1'b1;
                c_hway = WW'(w);
            end
            if (state_q[s_set][w] != INV && tag_q[s_set][w] == s_tag) begin
                s_hit  = 1'b1;
                s_hway = WW'(w);
            end
            if (state_q[c_set][w] == INV) begin
                inv_found = 1'b1;
                inv_way   = WW'(w);
            end
        end
        vnode = 1;
        pbits = '0;
        for (int l = 0; l < SET_ASSOCIATIVITY; l++) begin
            pbits = plru_q[c_set] >> vnode;
            vnode = vnode * 2 + int'(pbits[0]);
        end
        plru_way = WW'(vnode - WAYS);
        victim   = c_hit ? c_hway : inv_found ? inv_way : plru_way;
        sel_way  = cpu_install_enable_i ? victim : c_hway;
        ev_state = state_q[c_set][sel_way];
        plru_new = plru_q[c_set];
        unode    = 1;
        wbit     = '0;
        for (int l = 0; l < SET_ASSOCIATIVITY; l++) begin
            wbit     = WW'(sel_way >> (SET_ASSOCIATIVITY - 1 - l));
            plru_new = (plru_new & ~(WAYS'(1) << unode)) | (WAYS'(!wbit[0]) << unode);
            unode    = unode * 2 + int'(wbit[0]);
        end
    end

    // A mutating CPU op on the very line being invalidated loses to the snoop.
    always_comb begin
        s_inv    = snoop_enable_i & snoop_invalidate_enable_i & s_hit;
        conflict = cpu_access_enable_i & s_inv & (c_set == s_set) & (c_tag == s_tag)
                 & (cpu_install_enable_i | cpu_write_enable_i | cpu_state_write_enable_i);
        go       = cpu_access_enable_i & ~conflict;
        do_inst  = go & cpu_install_enable_i;
        do_write = go & ~cpu_install_enable_i & cpu_write_enable_i & c_hit;
        do_state = go & ~cpu_install_enable_i & cpu_state_write_enable_i & c_hit;
        do_plru  = go & (c_hit | cpu_install_enable_i);
    end

    logic                   cpu_valid_q, cpu_hit_q, cpu_conflict_q, snoop_valid_q, snoop_hit_q;
    logic                   cpu_hit_d, cpu_conflict_d, snoop_hit_d;
    logic [WW-1:0]          cpu_way_q, cpu_way_d;
    logic [DATA_WIDTH-1:0]  cpu_data_q, cpu_data_d;
    logic [STATE_WIDTH-1:0] cpu_state_q, cpu_state_d, snoop_state_q, snoop_state_d;
    logic [TAG_WIDTH-1:0]   cpu_vtag_q, cpu_vtag_d;

    always_comb begin
        cpu_hit_d      = cpu_hit_q;
        cpu_conflict_d = cpu_conflict_q;
        cpu_way_d      = cpu_way_q;
        cpu_data_d     = cpu_data_q;
        cpu_state_d    = cpu_state_q;
        cpu_vtag_d     = cpu_vtag_q;
        snoop_hit_d    = snoop_hit_q;
        snoop_state_d  = snoop_state_q;
        if (cpu_access_enable_i) begin
            cpu_hit_d      = c_hit & ~conflict;
            cpu_conflict_d = conflict;
            cpu_way_d      = sel_way;
            cpu_data_d     = data_q[c_set][sel_way][c_off];
            cpu_state_d    = (cpu_install_enable_i | c_hit) ? ev_state : INV;
            cpu_vtag_d     = (cpu_install_enable_i && ev_state != INV) ? tag_q[c_set][sel_way] : '0;
        end
        if (snoop_enable_i) begin
            snoop_hit_d   = s_hit;
            snoop_state_d = s_hit ? state_q[s_set][s_hway] : INV;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= '{default: INV};
            plru_q         <= '{default: '0};
            cpu_valid_q    <= 1'b0;
            cpu_hit_q      <= 1'b0;
            cpu_conflict_q <= 1'b0;
            cpu_way_q      <= '0;
            cpu_data_q     <= '0;
            cpu_state_q    <= '0;
            cpu_vtag_q     <= '0;
            snoop_valid_q  <= 1'b0;
            snoop_hit_q    <= 1'b0;
            snoop_state_q  <= '0;
        end else begin
            if (s_inv) state_q[s_set][s_hway] <= INV;
            if (do_inst | do_state) state_q[c_set][sel_way] <= cpu_state_i;
            if (do_plru) plru_q[c_set] <= plru_new;
            cpu_valid_q    <= cpu_access_enable_i;
            cpu_hit_q      <= cpu_hit_d;
            cpu_conflict_q <= cpu_conflict_d;
            cpu_way_q      <= cpu_way_d;
            cpu_data_q     <= cpu_data_d;
            cpu_state_q    <= cpu_state_d;
            cpu_vtag_q     <= cpu_vtag_d;
            snoop_valid_q  <= snoop_enable_i;
            snoop_hit_q    <= snoop_hit_d;
            snoop_state_q  <= snoop_state_d;
        end
    end

    // Tags and data are never cleared; stale entries are masked by their INVALID state.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (do_inst) tag_q[c_set][sel_way] <= c_tag;
            if (do_inst | do_write) data_q[c_set][sel_way][c_off] <= cpu_data_i;
        end
    end

    assign cpu_valid_o      = cpu_valid_q;
    assign cpu_hit_o        = cpu_hit_q;
    assign cpu_conflict_o   = cpu_conflict_q;
    assign cpu_way_o        = cpu_way_q;
    assign cpu_data_o       = cpu_data_q;
    assign cpu_state_o      = cpu_state_q;
    assign cpu_victim_tag_o = cpu_vtag_q;
    assign snoop_valid_o    = snoop_valid_q;
    assign snoop_hit_o      = snoop_hit_q;
    assign snoop_state_o    = snoop_state_q;
endmodule

// File: tb/tb_set_associative_cache_unit_plru.sv
// tb_set_associative_cache_unit_plru: directed vector table with hand-computed expectations,
// plus hand-written reset sequences.
module tb_set_associative_cache_unit_plru;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [15:0] cpu_address = '0, snoop_address = '0, cpu_data_in = '0;
    logic        cpu_acc = 1'b0, cpu_wr = 1'b0, cpu_inst = 1'b0, cpu_swe = 1'b0;
    logic [1:0]  cpu_state_in = '0;
    logic        snoop_en = 1'b0, snoop_inv = 1'b0;
    logic        cpu_valid, cpu_hit, cpu_conflict, snoop_valid, snoop_hit;
    logic [1:0]  cpu_way, cpu_state_out, snoop_state_out;
    logic [15:0] cpu_data_out;
    logic [5:0]  cpu_victim_tag;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    set_associative_cache_unit_plru dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_address_i(cpu_address), .cpu_access_enable_i(cpu_acc),
        .cpu_write_enable_i(cpu_wr), .cpu_install_enable_i(cpu_inst),
        .cpu_data_i(cpu_data_in), .cpu_state_i(cpu_state_in),
        .cpu_state_write_enable_i(cpu_swe),
        .cpu_valid_o(cpu_valid), .cpu_hit_o(cpu_hit), .cpu_conflict_o(cpu_conflict),
        .cpu_way_o(cpu_way), .cpu_data_o(cpu_data_out), .cpu_state_o(cpu_state_out),
        .cpu_victim_tag_o(cpu_victim_tag),
        .snoop_address_i(snoop_address), .snoop_enable_i(snoop_en),
        .snoop_invalidate_enable_i(snoop_inv),
        .snoop_valid_o(snoop_valid), .snoop_hit_o(snoop_hit), .snoop_state_o(snoop_state_out)
    );

    localparam logic [3:0] NO = 4'b0000, RD = 4'b1000, WR = 4'b1100, IN = 4'b1010, WS = 4'b1101;
    localparam logic [1:0] SN = 2'b00, SP = 2'b10, SI = 2'b11;
    localparam logic [9:0] MV = 10'd1, MH = 10'd2, MC = 10'd4, MW = 10'd8, MD = 10'd16,
                           MS = 10'd32, MT = 10'd64, MSV = 10'd128, MSH = 10'd256, MSS = 10'd512;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] d;
        logic [1:0]  si;
        logic [1:0]  sop;
        logic [15:0] sa;
        logic [9:0]  m;
        logic [2:0]  evhc;
        logic [1:0]  ew;
        logic [15:0] ed;
        logic [1:0]  es;
        logic [5:0]  et;
        logic [1:0]  esvh;
        logic [1:0]  ess;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] addr(logic [5:0] t, logic [5:0] s, logic [3:0] o);
        return {t, s, o};
    endfunction

    task automatic add(string n, logic [3:0] op, logic [15:0] a, logic [15:0] d, logic [1:0] si,
                       logic [1:0] sop, logic [15:0] sa, logic [9:0] m, logic [2:0] evhc,
                       logic [1:0] ew, logic [15:0] ed, logic [1:0] es, logic [5:0] et,
                       logic [1:0] esvh, logic [1:0] ess);
        vecs.push_back('{n, op, a, d, si, sop, sa, m, evhc, ew, ed, es, et, esvh, ess});
    endtask

    task automatic check(string n, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        {cpu_acc, cpu_wr, cpu_inst, cpu_swe} = v.op;
        cpu_address  = v.a;
        cpu_data_in  = v.d;
        cpu_state_in = v.si;
        {snoop_en, snoop_inv} = v.sop;
        snoop_address = v.sa;
        @(negedge clk);
        if (v.m[0]) check({v.name, ".valid"}, 16'(cpu_valid), 16'(v.evhc[2]));
        if (v.m[1]) check({v.name, ".hit"}, 16'(cpu_hit), 16'(v.evhc[1]));
        if (v.m[2]) check({v.name, ".conflict"}, 16'(cpu_conflict), 16'(v.evhc[0]));
        if (v.m[3]) check({v.name, ".way"}, 16'(cpu_way), 16'(v.ew));
        if (v.m[4]) check({v.name, ".data"}, cpu_data_out, v.ed);
        if (v.m[5]) check({v.name, ".state"}, 16'(cpu_state_out), 16'(v.es));
        if (v.m[6]) check({v.name, ".vtag"}, 16'(cpu_victim_tag), 16'(v.et));
        if (v.m[7]) check({v.name, ".svalid"}, 16'(snoop_valid), 16'(v.esvh[1]));
        if (v.m[8]) check({v.name, ".shit"}, 16'(snoop_hit), 16'(v.esvh[0]));
        if (v.m[9]) check({v.name, ".sstate"}, 16'(snoop_state_out), 16'(v.ess));
    endtask

    task automatic check_all_zero(string n);
        check({n, ".valid"}, 16'(cpu_valid), 16'd0);
        check({n, ".hit"}, 16'(cpu_hit), 16'd0);
        check({n, ".way"}, 16'(cpu_way), 16'd0);
        check({n, ".data"}, cpu_data_out, 16'd0);
        check({n, ".state"}, 16'(cpu_state_out), 16'd0);
        check({n, ".vtag"}, 16'(cpu_victim_tag), 16'd0);
        check({n, ".svalid"}, 16'(snoop_valid), 16'd0);
        check({n, ".sstate"}, 16'(snoop_state_out), 16'd0);
    endtask

    initial begin
        add("rd_cold", RD, addr(6'h2A, 7, 0), 0, 0, SN, 0, MV|MH|MC|MS|MSV, 3'b100, 0, 0, 0, 0, 2'b00, 0);
        add("inst5", IN, addr(5, 3, 1), 16'hBEEF, 2, SN, 0, MV|MH|MC|MW|MS|MT, 3'b100, 0, 0, 0, 0, 0, 0);
        add("rd5", RD, addr(5, 3, 1), 0, 0, SN, 0, MV|MH|MW|MD|MS, 3'b110, 0, 16'hBEEF, 2, 0, 0, 0);
        add("idle_hold", NO, 0, 0, 0, SN, 0, MV|MH|MD|MSV, 3'b010, 0, 16'hBEEF, 0, 0, 2'b00, 0);
        add("snp_inv5", NO, 0, 0, 0, SI, addr(5, 3, 7), MV|MSV|MSH|MSS, 3'b000, 0, 0, 0, 0, 2'b11, 2);
        add("rd5_gone", RD, addr(5, 3, 1), 0, 0, SN, 0, MV|MH|MS|MSV, 3'b100, 0, 0, 0, 0, 2'b00, 0);
        for (int t = 1; t <= 4; t++)
            add($sformatf("fill%0d", t), IN, addr(6'(t), 3, 0), 16'(t * 16'h1111), 1, SN, 0,
                MV|MH|MW|MT|MS, 3'b100, 2'(t - 1), 0, 0, 0, 0, 0);
        add("touch1", RD, addr(1, 3, 0), 0, 0, SN, 0, MV|MH|MW|MD|MS, 3'b110, 0, 16'h1111, 1, 0, 0, 0);
        add("touch3", RD, addr(3, 3, 0), 0, 0, SN, 0, MV|MH|MW|MD|MS, 3'b110, 2, 16'h3333, 1, 0, 0, 0);
        add("inst9", IN, addr(9, 3, 0), 16'h9999, 3, SN, 0, MV|MH|MW|MD|MS|MT, 3'b100, 1, 16'h2222, 1, 2, 0, 0);
        add("rd2_gone", RD, addr(2, 3, 0), 0, 0, SN, 0, MV|MH|MS, 3'b100, 0, 0, 0, 0, 0, 0);
        add("rd9", RD, addr(9, 3, 0), 0, 0, SN, 0, MV|MH|MW|MD|MS, 3'b110, 1, 16'h9999, 3, 0, 0, 0);
        add("instA", IN, addr(6'h0A, 3, 0), 16'h0AAA, 1, SN, 0, MV|MH|MW|MD|MS|MT, 3'b100, 3, 16'h4444, 1, 4, 0, 0);
        add("inst11", IN, addr(6'h11, 5, 2), 16'hAAAA, 2, SN, 0, MV|MH|MW|MS|MT, 3'b100, 0, 0, 0, 0, 0, 0);
        add("wr_vs_inv", WR, addr(6'h11, 5, 2), 16'h1234, 0, SI, addr(6'h11, 5, 0),
            MV|MH|MC|MSV|MSH|MSS, 3'b101, 0, 0, 0, 0, 2'b11, 2);
        add("rd11_gone", RD, addr(6'h11, 5, 2), 0, 0, SN, 0, MV|MH|MS, 3'b100, 0, 0, 0, 0, 0, 0);
        add("reinst11", IN, addr(6'h11, 5, 3), 16'h5555, 1, SN, 0, MV|MH|MW|MT, 3'b100, 0, 0, 0, 0, 0, 0);
        add("rd11_old", RD, addr(6'h11, 5, 2), 0, 0, SN, 0, MV|MH|MW|MD|MS, 3'b110, 0, 16'hAAAA, 1, 0, 0, 0);
        add("rd_vs_inv", RD, addr(6'h11, 5, 2), 0, 0, SI, addr(6'h11, 5, 9),
            MV|MH|MC|MD|MS|MSV|MSH|MSS, 3'b110, 0, 16'hAAAA, 1, 0, 2'b11, 1);
        add("rd11_inv", RD, addr(6'h11, 5, 2), 0, 0, SN, 0, MV|MH|MS, 3'b100, 0, 0, 0, 0, 0, 0);
        add("wr_other_tag", WS, addr(3, 3, 0), 16'h7777, 2, SI, addr(1, 3, 0),
            MV|MH|MC|MW|MD|MS|MSV|MSH|MSS, 3'b110, 2, 16'h3333, 1, 0, 2'b11, 1);
        add("rd3_new", RD, addr(3, 3, 0), 0, 0, SP, addr(1, 3, 0),
            MV|MH|MW|MD|MS|MSV|MSH|MSS, 3'b110, 2, 16'h7777, 2, 0, 2'b10, 0);
        add("wr_miss", WR, addr(6'h3F, 3, 0), 16'hDEAD, 0, SN, 0, MV|MH|MC|MS, 3'b100, 0, 0, 0, 0, 0, 0);
        add("rd1_gone", RD, addr(1, 3, 0), 0, 0, SN, 0, MV|MH, 3'b100, 0, 0, 0, 0, 0, 0);
        add("rdA", RD, addr(6'h0A, 3, 0), 0, 0, SN, 0, MV|MH|MW|MD, 3'b110, 3, 16'h0AAA, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        check_all_zero("in_reset");
        rst_n = 1'b1;
        foreach (vecs[i]) apply(vecs[i]);

        // Reset lands while an install result is on the outputs.
        apply('{"mid_inst", IN, addr(6'h20, 9, 0), 16'h0001, 2, SN, 0, MV, 3'b100, 0, 0, 0, 0, 0, 0});
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        cpu_acc = 1'b0;
        cpu_inst = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply('{"post_rst9", RD, addr(9, 3, 0), 0, 0, SN, 0, MV|MH|MS, 3'b100, 0, 0, 0, 0, 0, 0});
        apply('{"post_rst20", RD, addr(6'h20, 9, 0), 0, 0, SN, 0, MV|MH|MS, 3'b100, 0, 0, 0, 0, 0, 0});
        apply('{"post_rst3", RD, addr(3, 3, 0), 0, 0, SN, 0, MV|MH|MS, 3'b100, 0, 0, 0, 0, 0, 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
